// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the memory-stage bus controller.
// Access-size decode and misalignment rule live here for reuse by trap logic.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] encodes size for loads and stores alike
  function automatic logic misalign(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic w_half;
    logic w_word;
    w_half = (f3[1:0] == 2'b01);
    w_word = (f3[1:0] == 2'b10);
    return (w_half & lo[0]) | (w_word & (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational misalignment detect for data-memory accesses.
// Bytes are never misaligned; halves need bit 0 clear, words bits 1:0 clear.
module dmem_align_chk
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0] i_opsel,
  input  logic [1:0] i_addr_lo,
  output logic       o_misaligned
);

  assign o_misaligned = misalign(i_opsel, i_addr_lo);

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage bus controller: single-outstanding req/ready/valid access
// to a multi-cycle data memory with pipeline stall and timeout abort.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [2:0]  i_opsel,
  input  logic [31:0] i_addr_raw,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_mask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_wen;
  logic [31:0]        r_addr;
  logic [3:0]         r_mask;
  logic [31:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic               w_align;
  logic               w_acc;
  logic               w_mis;
  logic               w_issue;
  logic               w_busy;
  logic               w_timeout;
  logic               w_done_ok;
  logic               w_abort;
  logic               w_unused;

  assign w_unused = ^i_addr_raw[31:2];

  dmem_align_chk u_align (
    .i_opsel      (i_opsel),
    .i_addr_lo    (i_addr_raw[1:0]),
    .o_misaligned (w_align)
  );

  assign w_acc     = i_req_valid & (i_req_ren | i_req_wen);
  assign w_mis     = w_acc & w_align;
  assign w_issue   = (r_state == S_IDLE) & w_acc & ~w_mis;
  assign w_busy    = (r_state == S_REQ) | (r_state == S_WAIT);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  assign w_done_ok = ((r_state == S_REQ) & i_mem_ready & i_mem_valid)
                   | ((r_state == S_WAIT) & i_mem_valid);
  assign w_abort   = w_busy & ~w_done_ok & w_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // completion beats timeout when both land in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_done_ok)        w_state_nxt = S_DONE;
        else if (w_timeout)   w_state_nxt = S_DONE;
        else if (i_mem_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_ok || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req = 1'b0;
    o_stall   = 1'b0;
    o_rvalid  = 1'b0;
    o_bus_err = 1'b0;
    unique case (r_state)
      S_IDLE: o_stall = w_issue;
      S_REQ: begin
        o_mem_req = 1'b1;
        o_stall   = 1'b1;
      end
      S_WAIT: o_stall = 1'b1;
      S_DONE: begin
        o_rvalid  = 1'b1;
        o_bus_err = r_err;
      end
      default: o_stall = 1'b0;
    endcase
    if (i_rst) o_stall = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_mask  <= '0;
      r_wdata <= '0;
    end else if (w_issue) begin
      r_wen   <= i_req_wen;
      r_addr  <= i_addr;
      r_mask  <= i_mask;
      r_wdata <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // stores return a zero word; aborts return zero with the error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_done_ok) begin
      r_rdata <= r_wen ? 32'h0 : i_mem_rdata;
      r_err   <= 1'b0;
    end else if (w_abort) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

  assign o_rdata      = r_rdata;
  assign o_misaligned = w_mis;
  assign o_mem_wen    = r_wen;
  assign o_mem_addr   = r_addr;
  assign o_mem_mask   = r_mask;
  assign o_mem_wdata  = r_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a hand-driven memory.
// Built with TIMEOUT=8 so the abort path is reachable quickly.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ren;
  logic        req_wen;
  logic [2:0]  opsel;
  logic [31:0] addr_raw;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misal;
  logic        bus_err;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.TIMEOUT(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_ren    (req_ren),
    .i_req_wen    (req_wen),
    .i_opsel      (opsel),
    .i_addr_raw   (addr_raw),
    .i_addr       (addr),
    .i_mask       (mask),
    .i_wdata      (wdata),
    .o_stall      (stall),
    .o_rdata      (rdata),
    .o_rvalid     (rvalid),
    .o_misaligned (misal),
    .o_bus_err    (bus_err),
    .o_mem_req    (mem_req),
    .o_mem_wen    (mem_wen),
    .o_mem_addr   (mem_addr),
    .o_mem_mask   (mem_mask),
    .o_mem_wdata  (mem_wdata),
    .i_mem_ready  (mem_ready),
    .i_mem_valid  (mem_valid),
    .i_mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic [2:0] f3,
                           input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] d);
    req_valid = 1'b1;
    req_wen   = wen;
    req_ren   = ~wen;
    opsel     = f3;
    addr_raw  = a;
    addr      = {a[31:2], 2'b00};
    mask      = m;
    wdata     = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    nxt();
    nxt();
    #1;
    checks++;
    if (stall !== 1'b0 || rvalid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl stall=%b rvalid=%b req=%b want 000",
               stall, rvalid, mem_req);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_mask !== 4'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs addr=%h mask=%h rdata=%h want 0",
               mem_addr, mem_mask, rdata);
    end
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_load_wait;
    int nstall;
    nstall = 0;
    drive_req(1'b0, F3_LW, 32'h100, 4'hF, 32'h0);
    #1;
    if (stall === 1'b1) nstall++;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_issue stall=%b req=%b want 1 0", stall, mem_req);
    end
    nxt();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    #1;
    if (stall === 1'b1) nstall++;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 ||
        mem_mask !== 4'hF || mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL lw_req req=%b addr=%h mask=%h wen=%b want 1 100 f 0",
               mem_req, mem_addr, mem_mask, mem_wen);
    end
    nxt();
    mem_ready = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    if (stall === 1'b1) nstall++;
    checks++;
    if (mem_req !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL lw_wait req=%b rvalid=%b want 0 0", mem_req, rvalid);
    end
    nxt();
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
    #1;
    if (stall === 1'b1) nstall++;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_done rvalid=%b rdata=%h err=%b want 1 deadbeef 0",
               rvalid, rdata, bus_err);
    end
    checks++;
    if (nstall != 3) begin
      errors++;
      $display("FAIL lw_stall_cycles got %0d want 3", nstall);
    end
    nxt();
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL lw_pulse rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_store_hold;
    drive_req(1'b1, F3_SB, 32'h203, 4'b1000, 32'hAB000000);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue stall=%b want 1", stall);
    end
    nxt();
    req_valid = 1'b0;
    addr      = 32'hFFFF_FFF0;
    mask      = 4'hF;
    wdata     = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 32'h200 ||
          mem_mask !== 4'b1000 || mem_wdata !== 32'hAB000000) begin
        errors++;
        $display("FAIL sb_hold%0d req=%b wen=%b addr=%h mask=%b wd=%h", i,
                 mem_req, mem_wen, mem_addr, mem_mask, mem_wdata);
      end
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL sb_accept req=%b stall=%b want 1 1", mem_req, stall);
    end
    nxt();
    mem_ready = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    nxt();
    mem_valid = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_done rvalid=%b rdata=%h stall=%b want 1 0 0",
               rvalid, rdata, stall);
    end
    nxt();
  endtask

  task automatic test_misalign;
    drive_req(1'b0, F3_LH, 32'h101, 4'b0011, 32'h0);
    #1;
    checks++;
    if (misal !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL lh_mis misal=%b stall=%b want 1 0", misal, stall);
    end
    nxt();
    #1;
    checks++;
    if (mem_req !== 1'b0 || misal !== 1'b1) begin
      errors++;
      $display("FAIL lh_noreq req=%b misal=%b want 0 1", mem_req, misal);
    end
    drive_req(1'b0, F3_LW, 32'h102, 4'hF, 32'h0);
    #1;
    checks++;
    if (misal !== 1'b1) begin
      errors++;
      $display("FAIL lw_mis misal=%b want 1", misal);
    end
    drive_req(1'b0, F3_LB, 32'h101, 4'b0010, 32'h0);
    #1;
    checks++;
    if (misal !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL lb_ok misal=%b stall=%b want 0 1", misal, stall);
    end
    nxt();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_mask !== 4'b0010) begin
      errors++;
      $display("FAIL lb_req req=%b addr=%h mask=%b want 1 100 0010",
               mem_req, mem_addr, mem_mask);
    end
    nxt();
    mem_ready = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'h0000_AA00;
    nxt();
    mem_valid = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0000_AA00) begin
      errors++;
      $display("FAIL lb_done rvalid=%b rdata=%h want 1 0000aa00",
               rvalid, rdata);
    end
    nxt();
  endtask

  task automatic test_back_to_back;
    drive_req(1'b0, F3_LW, 32'h300, 4'hF, 32'h0);
    nxt();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    nxt();
    mem_ready = 1'b0;
    mem_valid = 1'b0;
    drive_req(1'b0, F3_LW, 32'h304, 4'hF, 32'h0);
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hCAFE_F00D ||
        stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL zl_done rvalid=%b rdata=%h stall=%b req=%b",
               rvalid, rdata, stall, mem_req);
    end
    nxt();
    #1;
    checks++;
    if (stall !== 1'b1 || rvalid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_issue stall=%b rvalid=%b req=%b want 1 0 0",
               stall, rvalid, mem_req);
    end
    nxt();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'h0BAD_CAFE;
    #1;
    checks++;
    if (mem_addr !== 32'h304) begin
      errors++;
      $display("FAIL b2b_addr addr=%h want 304", mem_addr);
    end
    nxt();
    mem_ready = 1'b0;
    mem_valid = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL b2b_done rvalid=%b rdata=%h want 1 0badcafe",
               rvalid, rdata);
    end
    nxt();
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    drive_req(1'b0, F3_LW, 32'h400, 4'hF, 32'h0);
    nxt();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rvalid !== 1'b0 || stall !== 1'b1) early++;
      nxt();
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL to_early bad_cycles=%0d want 0", early);
    end
    #1;
    checks++;
    if (rvalid !== 1'b1 || bus_err !== 1'b1 ||
        rdata !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL to_abort rvalid=%b err=%b rdata=%h stall=%b",
               rvalid, bus_err, rdata, stall);
    end
    nxt();
    #1;
    checks++;
    if (rvalid !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear rvalid=%b err=%b want 0 0", rvalid, bus_err);
    end
  endtask

  task automatic test_reset_mid;
    drive_req(1'b0, F3_LW, 32'h500, 4'hF, 32'h0);
    nxt();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    nxt();
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall stall=%b want 0", stall);
    end
    nxt();
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'h7777_7777;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle req=%b stall=%b rvalid=%b want 000",
               mem_req, stall, rvalid);
    end
    nxt();
    mem_valid = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_norv rvalid=%b want 0", rvalid);
    end
    drive_req(1'b0, F3_LW, 32'h600, 4'hF, 32'h0);
    nxt();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'h600D_600D;
    nxt();
    mem_ready = 1'b0;
    mem_valid = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h600D_600D || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_after rvalid=%b rdata=%h err=%b want 1 600d600d 0",
               rvalid, rdata, bus_err);
    end
    nxt();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    opsel     = 3'b000;
    addr_raw  = 32'h0;
    addr      = 32'h0;
    mask      = 4'h0;
    wdata     = 32'h0;
    mem_ready = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_load_wait();
    test_store_hold();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time expired");
    $fatal(1, "watchdog");
  end

endmodule
